// File: rtl/truth_table_capture_pkg.sv
// Shared types and helpers for the truth-table capture block.
package tt_capture_pkg;

  localparam int MAX_N_IN = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  function automatic int TT_W(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/truth_table_capture_if.sv
// Control and loopback signals between the capture engine and its host / gate under test.
interface truth_table_capture_if
  import tt_capture_pkg::*;
#(
  parameter int N_IN = 3
);

  localparam int TTW = TT_W(N_IN);

  logic            start;
  logic            busy;
  logic            done;
  logic [TTW-1:0]  tt;
  logic [TTW-1:0]  unstable;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;

  modport master (
    output start,
    input  busy,
    input  done,
    input  tt,
    input  unstable,
    input  dut_in,
    output dut_out
  );

  modport slave (
    input  start,
    output busy,
    output done,
    output tt,
    output unstable,
    output dut_in,
    input  dut_out
  );

endinterface

// File: rtl/truth_table_capture_sync2.sv
// Two-flop synchroniser for a single asynchronous bit, resets to 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/truth_table_capture.sv
// Sweeps every input combination of an external N-input gate and captures its
// synchronised output into a hex truth-table word, flagging combinations whose samples disagree.
module truth_table_capture
  import tt_capture_pkg::*;
#(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_capture_if.slave  bus
);

  localparam int TTW     = TT_W(N_IN);
  localparam int IDX_W   = N_IN + 1;
  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0]    SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]    SAMPLE_LOAD = CW'(SAMPLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(TTW - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N_IN-1:0]   dut_in_q, dut_in_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ref_q, ref_d;
  logic [TTW-1:0]    tt_q, tt_d;
  logic [TTW-1:0]    unstable_q, unstable_d;

  logic              out_s;
  logic              cnt_zero;
  logic              first_sample;
  logic              last_idx;
  logic [IDX_W-1:0]  idx_inc;
  logic [N_IN-1:0]   bit_pos;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.dut_out),
    .q     (out_s)
  );

  assign cnt_zero     = (cnt_q == '0);
  assign first_sample = (cnt_q == SAMPLE_LOAD);
  assign last_idx     = (idx_q == IDX_LAST);
  assign idx_inc      = idx_q + 1'b1;
  // Combination i lands in tt[2^N-1-i], which is simply the bitwise inverse of i.
  assign bit_pos      = ~idx_q[N_IN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = SETTLE;
      SETTLE:  if (cnt_zero) state_d = SAMPLE;
      SAMPLE:  if (cnt_zero) state_d = last_idx ? DONE : SETTLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == SETTLE) || (state_q == SAMPLE);
    bus.done = (state_q == DONE);
  end

  always_comb begin
    idx_d      = idx_q;
    dut_in_d   = dut_in_q;
    cnt_d      = cnt_q;
    ref_d      = ref_q;
    tt_d       = tt_q;
    unstable_d = unstable_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          idx_d      = '0;
          dut_in_d   = '0;
          cnt_d      = SETTLE_LOAD;
          tt_d       = '0;
          unstable_d = '0;
        end
      end
      SETTLE: begin
        cnt_d = cnt_zero ? SAMPLE_LOAD : cnt_q - 1'b1;
      end
      SAMPLE: begin
        // The first sample of each combination is both the result and the reference.
        if (first_sample) begin
          ref_d         = out_s;
          tt_d[bit_pos] = out_s;
        end else if (out_s != ref_q) begin
          unstable_d[bit_pos] = 1'b1;
        end
        if (cnt_zero) begin
          cnt_d = SETTLE_LOAD;
          if (!last_idx) begin
            idx_d    = idx_inc;
            dut_in_d = idx_inc[N_IN-1:0];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      dut_in_q   <= '0;
      cnt_q      <= '0;
      ref_q      <= 1'b0;
      tt_q       <= '0;
      unstable_q <= '0;
    end else begin
      idx_q      <= idx_d;
      dut_in_q   <= dut_in_d;
      cnt_q      <= cnt_d;
      ref_q      <= ref_d;
      tt_q       <= tt_d;
      unstable_q <= unstable_d;
    end
  end

  assign bus.dut_in   = dut_in_q;
  assign bus.tt       = tt_q;
  assign bus.unstable = unstable_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed bench: a 3-input gate model on the default instance and an XOR model on a 2-input instance.
module tb_truth_table_capture;

  logic clk;
  logic rst_n;

  logic [1:0] modeA;
  logic       glitch;

  int compared;
  int mismatched;

  truth_table_capture_if #(.N_IN(3)) busA ();
  truth_table_capture_if #(.N_IN(2)) busB ();

  truth_table_capture #(
    .N_IN          (3),
    .SETTLE_CYCLES (4),
    .SAMPLE_CYCLES (3)
  ) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA.slave)
  );

  truth_table_capture #(
    .N_IN          (2),
    .SETTLE_CYCLES (3),
    .SAMPLE_CYCLES (1)
  ) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB.slave)
  );

  function automatic logic gate3(input logic [2:0] x);
    return (x == 3'b011) || (x == 3'b101) || (x == 3'b110);
  endfunction

  // modeA: 0 gate model, 1 tied high, 2 tied low; glitch inverts the gate model
  assign busA.dut_out = (modeA == 2'd0) ? (gate3(busA.dut_in) ^ glitch) :
                        (modeA == 2'd1) ? 1'b1 : 1'b0;
  assign busB.dut_out = busB.dut_in[1] ^ busB.dut_in[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Pulses start across one rising edge and leaves time just past that edge.
  task automatic applyStimulus(input bit useB);
    if (useB) busB.start = 1'b1;
    else      busA.start = 1'b1;
    @(posedge clk);
    #1;
    busA.start = 1'b0;
    busB.start = 1'b0;
  endtask

  // Counts edges until done is seen; optionally re-pulses start at cycles 10 and 30.
  task automatic waitDone(input int maxCycles, input bit useB, input bit pulseExtra, output int cycles);
    int n;
    n = 0;
    while (n < maxCycles) begin
      @(posedge clk);
      #1;
      n++;
      if (!useB) busA.start = pulseExtra && ((n == 10) || (n == 30));
      if (useB ? busB.done : busA.done) break;
    end
    busA.start = 1'b0;
    cycles = n;
  endtask

  initial begin
    int cycles;
    int extraDones;
    compared   = 0;
    mismatched = 0;
    modeA      = 2'd0;
    glitch     = 1'b0;
    busA.start = 1'b0;
    busB.start = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busA.busy), 32'd0);
    checkOutput("reset_done", 32'(busA.done), 32'd0);
    checkOutput("reset_tt", 32'(busA.tt), 32'h00);
    checkOutput("reset_unstable", 32'(busA.unstable), 32'h00);
    checkOutput("reset_dut_in", 32'(busA.dut_in), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] gate model sweep");
    applyStimulus(1'b0);
    checkOutput("busy_after_start", 32'(busA.busy), 32'd1);
    waitDone(200, 1'b0, 1'b0, cycles);
    checkOutput("gate_latency", 32'(cycles), 32'd56);
    checkOutput("gate_busy_in_done", 32'(busA.busy), 32'd0);
    checkOutput("gate_tt", 32'(busA.tt), 32'h16);
    checkOutput("gate_unstable", 32'(busA.unstable), 32'h00);
    busA.start = 1'b1;
    @(posedge clk);
    #1;
    busA.start = 1'b0;
    checkOutput("start_with_done_ignored", 32'(busA.busy), 32'd0);
    checkOutput("done_one_cycle", 32'(busA.done), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("tt_held_after_done", 32'(busA.tt), 32'h16);

    $display("[TB] constant outputs");
    modeA = 2'd1;
    applyStimulus(1'b0);
    waitDone(200, 1'b0, 1'b0, cycles);
    checkOutput("ones_tt", 32'(busA.tt), 32'hFF);
    checkOutput("ones_unstable", 32'(busA.unstable), 32'h00);
    @(posedge clk);
    #1;
    modeA = 2'd2;
    applyStimulus(1'b0);
    checkOutput("start_clears_tt", 32'(busA.tt), 32'h00);
    waitDone(200, 1'b0, 1'b0, cycles);
    checkOutput("zeros_tt", 32'(busA.tt), 32'h00);
    checkOutput("zeros_unstable", 32'(busA.unstable), 32'h00);
    @(posedge clk);
    #1;

    $display("[TB] glitch on combination 5");
    modeA = 2'd0;
    applyStimulus(1'b0);
    repeat (38) @(posedge clk);
    #1;
    checkOutput("glitch_dut_in", 32'(busA.dut_in), 32'd5);
    glitch = 1'b1;
    @(posedge clk);
    #1;
    glitch = 1'b0;
    waitDone(200, 1'b0, 1'b0, cycles);
    checkOutput("glitch_remaining_latency", 32'(cycles), 32'd17);
    checkOutput("glitch_tt", 32'(busA.tt), 32'h16);
    checkOutput("glitch_unstable", 32'(busA.unstable), 32'h04);
    @(posedge clk);
    #1;

    $display("[TB] start while busy");
    applyStimulus(1'b0);
    waitDone(200, 1'b0, 1'b1, cycles);
    checkOutput("restart_latency", 32'(cycles), 32'd56);
    checkOutput("restart_tt", 32'(busA.tt), 32'h16);
    checkOutput("restart_unstable", 32'(busA.unstable), 32'h00);
    extraDones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (busA.done) extraDones++;
    end
    checkOutput("restart_single_done", 32'(extraDones), 32'd0);

    $display("[TB] reset mid-sweep");
    applyStimulus(1'b0);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", 32'(busA.busy), 32'd0);
    checkOutput("midreset_done", 32'(busA.done), 32'd0);
    checkOutput("midreset_tt", 32'(busA.tt), 32'h00);
    checkOutput("midreset_dut_in", 32'(busA.dut_in), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b0);
    waitDone(200, 1'b0, 1'b0, cycles);
    checkOutput("postreset_latency", 32'(cycles), 32'd56);
    checkOutput("postreset_tt", 32'(busA.tt), 32'h16);
    @(posedge clk);
    #1;

    $display("[TB] two-input XOR instance");
    applyStimulus(1'b1);
    checkOutput("xor_busy", 32'(busB.busy), 32'd1);
    waitDone(200, 1'b1, 1'b0, cycles);
    checkOutput("xor_latency", 32'(cycles), 32'd16);
    checkOutput("xor_tt", 32'(busB.tt), 32'h6);
    checkOutput("xor_unstable", 32'(busB.unstable), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
